// File: rtl/mem_access_pkg.sv
// mem_access_pkg: access sizes and controller FSM states shared by the sram access controller
package mem_access_pkg;
  typedef logic [1:0] mem_size_t;
  localparam mem_size_t SIZE_B = 2'b00;
  localparam mem_size_t SIZE_H = 2'b01;
  localparam mem_size_t SIZE_W = 2'b10;
  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;
endpackage

// File: rtl/lane_unit.sv
// lane_unit: little-endian lane extract/extend and lane merge for sub-word accesses
module lane_unit
  import mem_access_pkg::*;
(
  input  logic [31:0] rd_word,
  input  logic [1:0]  off,
  input  mem_size_t   size,
  input  logic        uns,
  input  logic [31:0] wr_data,
  output logic [31:0] ext,
  output logic [31:0] merged
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    b = rd_word[{off, 3'b000} +: 8];
    h = rd_word[{off[1], 4'b0000} +: 16];
    ext = size == SIZE_B ? {{24{b[7] & ~uns}}, b} : size == SIZE_H ? {{16{h[15] & ~uns}}, h} : rd_word;
    merged = rd_word;
    if (size == SIZE_B) merged[{off, 3'b000} +: 8] = wr_data[7:0];
    else if (size == SIZE_H) merged[{off[1], 4'b0000} +: 16] = wr_data[15:0];
    else merged = wr_data;
  end
endmodule

// File: rtl/sram_access_ctrl.sv
// sram_access_ctrl: valid/ready load/store front end for a word-wide sram with sub-word read-modify-write
module sram_access_ctrl
  import mem_access_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        sram_cs,
  output logic        sram_oe,
  output logic        sram_we,
  output logic [31:0] sram_addr,
  output logic [31:0] sram_din,
  input  logic [31:0] sram_dout
);
  localparam int CW = RD_LAT > 1 ? $clog2(RD_LAT) : 1;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic we_q, uns_q, err, acc, last;
  mem_size_t size_q;
  logic [1:0] off_q;
  logic [31:0] wdata_q, ext, merged;
  assign req_ready = state == IDLE;
  assign acc = req_valid && req_ready;
  assign err = req_size == 2'b11 || (req_size == SIZE_H && req_addr[0]) || (req_size == SIZE_W && req_addr[1:0] != 2'b00);
  assign last = cnt == CW'(RD_LAT - 1);
  lane_unit u_lane (
    .rd_word (sram_dout),
    .off     (off_q),
    .size    (size_q),
    .uns     (uns_q),
    .wr_data (wdata_q),
    .ext     (ext),
    .merged  (merged)
  );
  always_comb begin
    state_n = state;
    state_n = state == IDLE ? (acc ? (err ? RESP : (req_we && req_size == SIZE_W) ? WR : RD) : IDLE)
            : state == RD   ? (last ? (we_q ? WR : RESP) : RD)
            : state == WR   ? RESP
            : (rsp_ready ? IDLE : RESP);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      we_q      <= 1'b0;
      uns_q     <= 1'b0;
      size_q    <= SIZE_B;
      off_q     <= 2'b00;
      wdata_q   <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      sram_cs   <= 1'b0;
      sram_oe   <= 1'b0;
      sram_we   <= 1'b0;
      sram_addr <= '0;
      sram_din  <= '0;
    end else begin
      state     <= state_n;
      cnt       <= (state == RD && !last) ? cnt + 1'b1 : '0;
      sram_cs   <= state_n == RD || state_n == WR;
      sram_oe   <= state_n == RD;
      sram_we   <= state_n == WR;
      rsp_valid <= state_n == RESP;
      if (acc) begin
        we_q      <= req_we;
        uns_q     <= req_unsigned;
        size_q    <= req_size;
        off_q     <= req_addr[1:0];
        wdata_q   <= req_wdata;
        sram_addr <= {req_addr[31:2], 2'b00};
        sram_din  <= req_wdata;
        rsp_err   <= err;
        rsp_rdata <= '0;
      end
      if (state == RD && last) begin
        if (we_q) sram_din <= merged;
        else rsp_rdata <= ext;
      end
    end
  end
endmodule

// File: tb/tb_sram_access_ctrl.sv
// tb_sram_access_ctrl: directed load/store/error/stall/reset checks against a word-array reference model
module tb_sram_access_ctrl;
  localparam int RL = 1;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0, rsp_ready = 1'b1;
  logic [1:0] req_size = 2'b00;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic req_ready, rsp_valid, rsp_err, sram_cs, sram_oe, sram_we;
  logic [31:0] rsp_rdata, sram_addr, sram_din, sram_dout;
  logic [31:0] mem [0:255];
  logic [31:0] ref_mem [0:255];
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int rsp_at = 0;
  logic pend = 1'b0;
  logic chk_en = 1'b0;
  logic exp_err = 1'b0;
  logic [31:0] exp_rdata = '0;

  sram_access_ctrl #(.RD_LAT(RL)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .sram_cs      (sram_cs),
    .sram_oe      (sram_oe),
    .sram_we      (sram_we),
    .sram_addr    (sram_addr),
    .sram_din     (sram_din),
    .sram_dout    (sram_dout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign sram_dout = (sram_cs && sram_oe) ? mem[sram_addr[9:2]] : 32'hBAD0BAD0;
  always @(posedge clk) if (sram_cs && sram_we) mem[sram_addr[9:2]] <= sram_din;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, got, want, cyc);
    end
  endtask

  function automatic logic [31:0] load_val(input logic [31:0] w, input logic [1:0] size, input logic uns, input int off);
    logic [31:0] v;
    if (size == 2'b10) return w;
    if (size == 2'b00) begin
      v = (w >> (8 * off)) & 32'hFF;
      if (!uns && v >= 32'd128) v = v | 32'hFFFFFF00;
    end else begin
      v = (w >> (16 * (off / 2))) & 32'hFFFF;
      if (!uns && v >= 32'd32768) v = v | 32'hFFFF0000;
    end
    return v;
  endfunction

  // Every cycle: handshake/response expectations derived from the pending model transaction.
  always @(negedge clk) if (chk_en) begin
    chk("req_ready", {31'b0, req_ready}, {31'b0, !pend});
    chk("rsp_valid", {31'b0, rsp_valid}, {31'b0, pend && cyc >= rsp_at});
    if (rsp_valid) begin
      chk("rsp_rdata", rsp_rdata, exp_rdata);
      chk("rsp_err", {31'b0, rsp_err}, {31'b0, exp_err});
    end
    if (!pend || exp_err) chk("sram_cs_idle", {31'b0, sram_cs}, 32'd0);
  end

  task automatic xact(input logic we, input logic [1:0] size, input logic uns, input logic [31:0] addr,
                      input logic [31:0] wdata, input int stall, input int lit_lat, input logic [31:0] lit_data);
    int acc_cyc, first, n, off, idx, lat;
    logic e;
    logic [31:0] mask;
    off = int'(addr % 4);
    idx = int'((addr / 4) % 256);
    e = size == 2'b11 || (size == 2'b01 && addr % 2 != 0) || (size == 2'b10 && off != 0);
    exp_err = e;
    exp_rdata = (e || we) ? 32'd0 : load_val(ref_mem[idx], size, uns, off);
    if (!e && we) begin
      mask = size == 2'b00 ? 32'hFF : size == 2'b01 ? 32'hFFFF : 32'hFFFFFFFF;
      n = size == 2'b00 ? 8 * off : size == 2'b01 ? 16 * (off / 2) : 0;
      ref_mem[idx] = (ref_mem[idx] & ~(mask << n)) | ((wdata & mask) << n);
    end
    lat = e ? 1 : !we ? RL + 1 : size == 2'b10 ? 2 : RL + 2;
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
    if (!req_ready) begin
      $display("FAIL accept: req_ready got 0 want 1 (cycle %0d)", cyc);
      $fatal(1, "request not accepted");
    end
    acc_cyc = cyc;
    rsp_at = acc_cyc + lat;
    if (stall > 0) rsp_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    pend = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!rsp_valid && n < 20);
    first = cyc;
    chk("rsp_seen", {31'b0, rsp_valid}, 32'd1);
    chk("latency", first - acc_cyc, lit_lat);
    chk("err_lit", {31'b0, rsp_err}, {31'b0, lit_lat == 1});
    if (stall > 0) begin
      req_valid = 1'b1; req_size = 2'b11;
      repeat (stall) @(posedge clk);
      #1;
      req_valid = 1'b0; rsp_ready = 1'b1;
      @(negedge clk);
    end
    chk("rdata_lit", rsp_rdata, lit_data);
    @(posedge clk); #1;
    pend = 1'b0;
    if (we) chk("mem_word", mem[idx], ref_mem[idx]);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
    chk("rst_ctrl", {29'b0, sram_cs, sram_oe, sram_we}, 32'd0);
    chk("rst_addr", sram_addr, 32'd0);
    chk("rst_din", sram_din, 32'd0);
    reset = 1'b0;
    chk_en = 1'b1;
    xact(1, 2'b10, 0, 32'h100, 32'hDEADBEEF, 0, 2, 32'h0);
    xact(0, 2'b10, 0, 32'h100, 32'h0, 0, 2, 32'hDEADBEEF);
    xact(1, 2'b10, 0, 32'h100, 32'h11223344, 0, 2, 32'h0);
    xact(1, 2'b00, 0, 32'h102, 32'h00000080, 0, RL + 2, 32'h0);
    chk("byte_merge_lit", mem[64], 32'h11803344);
    xact(0, 2'b00, 0, 32'h102, 32'h0, 0, 2, 32'hFFFFFF80);
    xact(0, 2'b00, 1, 32'h102, 32'h0, 0, 2, 32'h00000080);
    xact(1, 2'b10, 0, 32'h100, 32'h8001ABCD, 0, 2, 32'h0);
    xact(0, 2'b01, 0, 32'h102, 32'h0, 0, 2, 32'hFFFF8001);
    xact(0, 2'b01, 1, 32'h102, 32'h0, 0, 2, 32'h00008001);
    xact(0, 2'b00, 0, 32'h100, 32'h0, 0, 2, 32'hFFFFFFCD);
    xact(0, 2'b00, 1, 32'h101, 32'h0, 0, 2, 32'h000000AB);
    xact(0, 2'b01, 0, 32'h100, 32'h0, 0, 2, 32'hFFFFABCD);
    xact(0, 2'b10, 0, 32'h101, 32'h0, 0, 1, 32'h0);
    xact(0, 2'b01, 0, 32'h103, 32'h0, 0, 1, 32'h0);
    xact(0, 2'b11, 0, 32'h100, 32'h0, 0, 1, 32'h0);
    xact(1, 2'b01, 0, 32'h101, 32'h5555, 0, 1, 32'h0);
    xact(0, 2'b10, 0, 32'h100, 32'h0, 5, 2, 32'h8001ABCD);
    xact(1, 2'b10, 0, 32'h104, 32'hCAFEF00D, 0, 2, 32'h0);
    chk_en = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b01; req_unsigned = 1'b0; req_addr = 32'h106; req_wdata = 32'h1234;
    @(posedge clk); #1;
    req_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort_req_ready", {31'b0, req_ready}, 32'd1);
    chk("abort_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("abort_rsp_rdata", rsp_rdata, 32'd0);
    chk("abort_rsp_err", {31'b0, rsp_err}, 32'd0);
    chk("abort_ctrl", {29'b0, sram_cs, sram_oe, sram_we}, 32'd0);
    chk("abort_addr", sram_addr, 32'd0);
    chk("abort_din", sram_din, 32'd0);
    chk_en = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("abort_mem_lit", mem[65], 32'hCAFEF00D);
    xact(1, 2'b01, 0, 32'h106, 32'h0000BEEF, 0, RL + 2, 32'h0);
    xact(0, 2'b10, 0, 32'h104, 32'h0, 0, 2, 32'hBEEFF00D);
    xact(1, 2'b00, 0, 32'h104, 32'h000001FF, 0, RL + 2, 32'h0);
    xact(0, 2'b01, 0, 32'h104, 32'h0, 0, 2, 32'hFFFFF0FF);
    chk("final_mem_lit", mem[65], 32'hBEEFF0FF);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sram_access_ctrl.md
# sram_access_ctrl

Load/store access controller that sits directly upstream of the data-memory `sram` model in the single-cycle processor. It accepts one byte, halfword or word request at a time from the datapath over a valid/ready handshake and converts it into `sram` word accesses by driving `cs`, `oe`, `we`, `addr` and `din`. Sub-word stores are done as read-modify-write. Loads are lane-extracted and sign- or zero-extended. Results return over a valid/ready response channel.

## Interface
- `RD_LAT`, default 1: cycles `oe` is held before `sram_dout` is captured (≥1).
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: controller can accept a request.
- `req_we` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 byte, 01 half, 10 word, 11 illegal.
- `req_unsigned` in 1: loads only; 1 = zero-extend, 0 = sign-extend.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-justified.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: consumer accepts the response.
- `rsp_rdata` out 32: extended load data; 0 for stores and errors.
- `rsp_err` out 1: misaligned address or illegal size.
- `sram_cs`, `sram_oe`, `sram_we` out 1 each: `sram` controls.
- `sram_addr` out 32: word address `{req_addr[31:2],2'b00}`.
- `sram_din` out 32: write word.
- `sram_dout` in 32: read word.

## Operation
- FSM states: IDLE, RD, WR, RESP. All outputs are registered except `req_ready`, which equals `state==IDLE`.
- IDLE: `sram_cs`, `sram_oe` and `sram_we` are 0. A request is accepted when `req_valid && req_ready`, and all request fields are latched on acceptance.
- Error check at accept:
  - Error when `req_size==11`, when half has `addr[0]==1`, or when word has `addr[1:0]!=0`.
  - On error, go to RESP with `rsp_err=1` and `rsp_rdata=0`. No `sram` activity occurs.
- Load: go to RD.
  - In RD, drive `cs=1`, `oe=1` and `sram_addr`, and count `RD_LAT` cycles.
  - On the last RD cycle, capture `sram_dout`, extract the lane and extend it. Then drop `cs`/`oe` and go to RESP.
- Word store: go to WR.
  - In WR, drive `cs=1`, `we=1`, `sram_addr` and `sram_din=req_wdata` for exactly one cycle, then go to RESP.
  - `din` and `addr` become valid on the same edge that raises `we`.
- Sub-word store: RD (same as a load) → merge the new lane into the captured word → WR with the merged word → RESP.
- Lanes are little-endian.
  - Byte k = `addr[1:0]` occupies bits [8k+7:8k].
  - Half h = `addr[1]` occupies bits [16h+15:16h].
- Extension: byte/half loads are sign-extended from bit 7/15 unless `req_unsigned=1`. Word loads pass through unchanged.
- RESP: `rsp_valid=1`, with `rsp_rdata`/`rsp_err` held stable until `rsp_ready`. Then return to IDLE. `rsp_valid` drops on the same edge.
- Controls are deasserted in IDLE/RESP. This guarantees that back-to-back accesses to the same address produce fresh edges on `sram` controls.

## Timing
- Reset values: state IDLE, `req_ready=1` after the reset edge, `rsp_valid=0`, `rsp_rdata=0`, `rsp_err=0`, and all `sram_*` outputs 0.
- Latencies are measured from the accept edge T to `rsp_valid` high, with `rsp_ready` held high:
  - Load: T+`RD_LAT`+1.
  - Word store: T+2.
  - Sub-word store: T+`RD_LAT`+2.
  - Error: T+1.
- Throughput: at most one outstanding request, with no pipelining. The cycle after RESP handshakes is IDLE, so a new accept can occur there at the earliest.
- `rsp_ready` low stalls in RESP indefinitely. The response must not change while stalled.
- Reset asserted in any state aborts the request on that edge. No response is issued, and `sram` controls drop to 0 at that edge.
- `req_valid` while not ready is ignored, and its fields are not sampled.

## Structure
- Package `mem_access_pkg` holds:
  - `SIZE_B`/`SIZE_H`/`SIZE_W` constants.
  - The FSM state enum.
  - The `mem_size_t` typedef.
- Combinational sub-module `lane_unit` performs both lane operations:
  - Extract/extend, with inputs word, `addr[1:0]`, size and unsigned.
  - Merge, with inputs old word, new data, `addr[1:0]` and size.
- The top-level contains the FSM, the `RD_LAT` counter and the registers.

## Test plan
- Word store then word load, `addr=0x100`, `wdata=0xDEADBEEF`:
  - Store response at T+2 with `err=0`.
  - Load returns `0xDEADBEEF` at T+2 (`RD_LAT=1`).
- Byte store `0x80` to `0x102` over `0x11223344`:
  - `sram` word becomes `0x11803344`.
  - Signed byte load returns `0xFFFFFF80`; unsigned byte load returns `0x00000080`.
- Half load from `0x102` of `0x8001ABCD`: signed returns `0xFFFF8001`, unsigned returns `0x00008001`.
- Word load at `0x101`, half at `0x103`, and `size=11`: each gives `rsp_err=1` and `rdata=0` at T+1, with `sram_cs` staying 0 throughout.
- `rsp_ready` held low 5 cycles after a load: `rsp_valid`/`rdata` are stable, `req_ready=0`, and IDLE is reached one cycle after `rsp_ready` rises.
- Reset asserted during RD of a sub-word store: no WR cycle, no response, `sram` word unchanged, and all outputs at reset values the next cycle.
